uart_csr_bank: RTL



---
 rtl/uart_csr_pkg.sv | 38 +++
 rtl/uart_csr_chan.sv | 123 ++++++++++++
 rtl/uart_csr_bank.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_csr_pkg.sv
// Shared definitions for the multi-channel UART CSR bank: control field layout,
// per-channel register offsets, STATUS/IRQ_EN bit positions and global addresses.
package uart_csr_pkg;

  typedef struct packed {
    logic loopback;
    logic two_stop;
    logic parity_odd;
    logic parity_en;
    logic rx_en;
    logic tx_en;
  } ctrl_t;

  // Word offsets inside a channel's 16-byte window (byte address bits [3:2])
  localparam logic [1:0] OFF_BAUD   = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_IRQ_EN = 2'd3;

  // STATUS bit positions
  localparam int ST_BUSY    = 0;
  localparam int ST_FREE    = 1;
  localparam int ST_PERR    = 2;
  localparam int ST_DONE    = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_CLR = 31;

  // IRQ_EN bit positions
  localparam int IE_PERR = 0;
  localparam int IE_DONE = 1;

  // Global register word addresses (byte address bits [7:2])
  localparam logic [5:0] GADDR_ID   = 6'h3C;
  localparam logic [5:0] GADDR_PEND = 6'h3D;

  localparam logic [15:0] ID_VAL = 16'h0A27;

endpackage

// File: rtl/uart_csr_chan.sv
// One UART channel's register set: baud divisor, control, sticky error/done
// flags, saturating parity-error counter, interrupt enables and registered irq.
module uart_csr_chan
  import uart_csr_pkg::*;
#(
  parameter int BAUD_W   = 16,
  parameter int BAUD_RST = 54
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        off,
  input  logic [31:0]       wdata,
  input  logic              parity_error,
  input  logic              busy,
  input  logic              free,
  output logic [31:0]       rdata,
  output logic [BAUD_W-1:0] baud_div,
  output logic [5:0]        ctrl,
  output logic              irq
);

  logic [BAUD_W-1:0] baud_r;
  ctrl_t             ctrl_r;
  logic [1:0]        irq_en_r;
  logic              perr_r;
  logic              done_r;
  logic [7:0]        cnt_r;
  logic              busy_q_r;
  logic              irq_r;

  logic              st_wr_s;
  logic              cnt_clr_s;
  logic              busy_fall_s;
  logic              perr_nxt_s;
  logic              done_nxt_s;
  logic [7:0]        cnt_nxt_s;
  logic              unused_s;

  assign st_wr_s     = wr_en & (off == OFF_STATUS);
  assign cnt_clr_s   = st_wr_s & wdata[ST_CNT_CLR];
  assign busy_fall_s = busy_q_r & ~busy;
  assign unused_s    = ^wdata;

  // Next state of sticky flags and counter; a hardware event beats a same-cycle clear
  always_comb begin
    perr_nxt_s = perr_r;
    done_nxt_s = done_r;
    cnt_nxt_s  = cnt_r;
    if (parity_error) begin
      perr_nxt_s = 1'b1;
    end else if (st_wr_s && wdata[ST_PERR]) begin
      perr_nxt_s = 1'b0;
    end else begin
      perr_nxt_s = perr_r;
    end
    if (busy_fall_s) begin
      done_nxt_s = 1'b1;
    end else if (st_wr_s && wdata[ST_DONE]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
    if (parity_error) begin
      if (cnt_clr_s) begin
        cnt_nxt_s = 8'd1;
      end else if (cnt_r == 8'hFF) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + 8'd1;
      end
    end else if (cnt_clr_s) begin
      cnt_nxt_s = 8'd0;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Register file, busy history and interrupt output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_r   <= BAUD_W'(BAUD_RST);
      ctrl_r   <= '0;
      irq_en_r <= 2'd0;
      perr_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= 8'd0;
      busy_q_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_en && (off == OFF_BAUD)) begin
        baud_r <= wdata[BAUD_W-1:0];
      end
      if (wr_en && (off == OFF_CTRL)) begin
        ctrl_r <= ctrl_t'(wdata[5:0]);
      end
      if (wr_en && (off == OFF_IRQ_EN)) begin
        irq_en_r <= wdata[1:0];
      end
      perr_r   <= perr_nxt_s;
      done_r   <= done_nxt_s;
      cnt_r    <= cnt_nxt_s;
      busy_q_r <= busy;
      irq_r    <= (perr_r & irq_en_r[IE_PERR]) | (done_r & irq_en_r[IE_DONE]);
    end
  end

  // Read view of the selected register from current (pre-update) state
  always_comb begin
    case (off)
      OFF_BAUD:   rdata = 32'(baud_r);
      OFF_CTRL:   rdata = {26'd0, ctrl_r};
      OFF_STATUS: rdata = {16'd0, cnt_r, 4'd0, done_r, perr_r, free, busy};
      OFF_IRQ_EN: rdata = {30'd0, irq_en_r};
      default:    rdata = 32'd0;
    endcase
  end

  assign baud_div = baud_r;
  assign ctrl     = ctrl_r;
  assign irq      = irq_r;

endmodule

// File: rtl/uart_csr_bank.sv
// Multi-channel UART CSR bank: address decode, read mux and single-outstanding
// response register in front of NUM_CH uart_csr_chan instances.
module uart_csr_bank
  import uart_csr_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int BAUD_W   = 16,
  parameter int BAUD_RST = 54
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_error,
  output logic [NUM_CH*BAUD_W-1:0] baud_div,
  output logic [NUM_CH*6-1:0]      ctrl,
  input  logic [NUM_CH-1:0]        parity_error,
  input  logic [NUM_CH-1:0]        busy,
  input  logic [NUM_CH-1:0]        free,
  output logic [NUM_CH-1:0]        irq,
  output logic                     irq_any
);

  logic              rsp_valid_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_error_r;

  logic              accept_s;
  logic              hi_zero_s;
  logic [3:0]        chan_idx_s;
  logic [1:0]        off_s;
  logic              chan_hit_s;
  logic              glob_s;
  logic [NUM_CH-1:0] chan_wr_s;
  logic [31:0]       chan_rdata_s [NUM_CH];
  logic [31:0]       rdata_s;
  logic              error_s;
  logic              unused_s;

  assign accept_s   = req_valid & ~rsp_valid_r;
  assign hi_zero_s  = ((req_addr >> 8) == '0);
  assign chan_idx_s = req_addr[7:4];
  assign off_s      = req_addr[3:2];
  assign chan_hit_s = hi_zero_s & (chan_idx_s < 4'(NUM_CH));
  assign glob_s     = hi_zero_s & ((req_addr[7:2] == GADDR_ID) | (req_addr[7:2] == GADDR_PEND));
  assign unused_s   = ^req_addr[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    assign chan_wr_s[c] = accept_s & req_write & chan_hit_s & (chan_idx_s == 4'(c));

    uart_csr_chan #(
      .BAUD_W   (BAUD_W),
      .BAUD_RST (BAUD_RST)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (chan_wr_s[c]),
      .off          (off_s),
      .wdata        (req_wdata),
      .parity_error (parity_error[c]),
      .busy         (busy[c]),
      .free         (free[c]),
      .rdata        (chan_rdata_s[c]),
      .baud_div     (baud_div[c*BAUD_W +: BAUD_W]),
      .ctrl         (ctrl[c*6 +: 6]),
      .irq          (irq[c])
    );
  end

  // Read mux and unmapped-address detection
  always_comb begin
    rdata_s = 32'd0;
    error_s = 1'b0;
    if (chan_hit_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rdata_s = rdata_s | ((chan_idx_s == 4'(c)) ? chan_rdata_s[c] : 32'd0);
      end
    end else if (glob_s) begin
      if (req_addr[7:2] == GADDR_ID) begin
        rdata_s = {ID_VAL, 12'd0, 4'(NUM_CH)};
      end else begin
        rdata_s = 32'(irq);
      end
    end else begin
      error_s = 1'b1;
    end
  end

  // Response register: load on accept, hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_error_r <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= (req_write | error_s) ? 32'd0 : rdata_s;
      rsp_error_r <= error_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_error_r <= 1'b0;
    end
  end

  assign req_ready = ~rsp_valid_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_error = rsp_error_r;
  assign irq_any   = |irq;

endmodule
